tlp_tx_sched: RTL and testbench

//  Arbitrates the single upstream PCIe TX stream of tlp_xcvr between three TLP sources:

---
 rtl/tlp_xcvr_pkg.sv | 21 ++
 rtl/tlp_tx_sched_ctr.sv | 26 ++
 rtl/tlp_tx_sched.sv | 189 ++++++++++++++++++
 tb/tb_tlp_tx_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the tlp_xcvr TX path: source identifiers, scheduler states and hiRun width.
package tlp_xcvr_pkg;

    typedef enum logic [1:0] {SRC_NONE, SRC_CPL, SRC_MTR, SRC_F2C} TxSrc;

    typedef enum logic [1:0] {ST_IDLE, ST_OWN_CPL, ST_OWN_MTR, ST_OWN_F2C} SchedState;

    localparam int HI_RUN_WIDTH = 8;

    function automatic TxSrc state_to_src(input SchedState s);
        TxSrc src;
        case (s)
            ST_OWN_CPL: src = SRC_CPL;
            ST_OWN_MTR: src = SRC_MTR;
            ST_OWN_F2C: src = SRC_F2C;
            default:    src = SRC_NONE;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/tlp_tx_sched_ctr.sv
// Up-counter with synchronous clear; saturates at MAX_VAL when SATURATE is set, otherwise wraps.
module tlp_tx_sched_ctr #(
    parameter int               WIDTH    = 8,
    parameter bit               SATURATE = 1'b0,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !(SATURATE && (r_count == MAX_VAL))) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/tlp_tx_sched.sv
// Whole-TLP arbiter for the upstream TX stream: CPL > MTR > F2C with an F2C anti-starvation run limit.
// Optional per-source TLP counters are built when TLP_TX_SCHED_STATS_EN is defined.
module tlp_tx_sched
    import tlp_xcvr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int HI_RUN_MAX = 8,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [DATA_WIDTH-1:0] cplData_in,
    input  logic                  cplValid_in,
    input  logic                  cplSop_in,
    input  logic                  cplEop_in,
    output logic                  cplReady_out,
    input  logic [DATA_WIDTH-1:0] mtrData_in,
    input  logic                  mtrValid_in,
    input  logic                  mtrSop_in,
    input  logic                  mtrEop_in,
    output logic                  mtrReady_out,
    input  logic [DATA_WIDTH-1:0] f2cData_in,
    input  logic                  f2cValid_in,
    input  logic                  f2cSop_in,
    input  logic                  f2cEop_in,
    output logic                  f2cReady_out,
    output logic [DATA_WIDTH-1:0] txData_out,
    output logic                  txValid_out,
    output logic                  txSop_out,
    output logic                  txEop_out,
    input  logic                  txReady_in,
    output TxSrc                  grant_out,
    output logic                  err_out
`ifdef TLP_TX_SCHED_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] cplCount_out,
    output logic [STAT_WIDTH-1:0] mtrCount_out,
    output logic [STAT_WIDTH-1:0] f2cCount_out
`endif
);

    localparam logic [HI_RUN_WIDTH-1:0] HI_RUN_LIMIT = HI_RUN_WIDTH'(HI_RUN_MAX);

    generate
        if (HI_RUN_MAX < 1 || HI_RUN_MAX > 255 || STAT_WIDTH < 1) begin : g_param_err
            $error("tlp_tx_sched: parameter out of range");
        end
    endgenerate

    SchedState               r_state;
    SchedState               w_state_next;
    logic                    w_req_cpl, w_req_mtr, w_req_f2c;
    logic [DATA_WIDTH-1:0]   w_own_data;
    logic                    w_own_valid, w_own_sop, w_own_eop;
    logic                    w_hs, w_eop_hs;
    logic                    w_hi_run_inc, w_hi_run_clr;
    logic [HI_RUN_WIDTH-1:0] w_hi_run;
    logic                    r_first;
    logic                    r_err;

    assign w_req_cpl = cplValid_in && cplSop_in;
    assign w_req_mtr = mtrValid_in && mtrSop_in;
    assign w_req_f2c = f2cValid_in && f2cSop_in;

    // Owner mux: data path and ready are purely combinational from the registered owner.
    always_comb begin : p_mux
        w_own_data   = '0;
        w_own_valid  = 1'b0;
        w_own_sop    = 1'b0;
        w_own_eop    = 1'b0;
        cplReady_out = 1'b0;
        mtrReady_out = 1'b0;
        f2cReady_out = 1'b0;
        case (r_state)
            ST_OWN_CPL: begin
                w_own_data   = cplData_in;
                w_own_valid  = cplValid_in;
                w_own_sop    = cplSop_in;
                w_own_eop    = cplEop_in;
                cplReady_out = txReady_in;
            end
            ST_OWN_MTR: begin
                w_own_data   = mtrData_in;
                w_own_valid  = mtrValid_in;
                w_own_sop    = mtrSop_in;
                w_own_eop    = mtrEop_in;
                mtrReady_out = txReady_in;
            end
            ST_OWN_F2C: begin
                w_own_data   = f2cData_in;
                w_own_valid  = f2cValid_in;
                w_own_sop    = f2cSop_in;
                w_own_eop    = f2cEop_in;
                f2cReady_out = txReady_in;
            end
            default: ;
        endcase
    end

    assign w_hs     = w_own_valid && txReady_in;
    assign w_eop_hs = w_hs && w_own_eop;

    assign txData_out  = w_own_data;
    assign txValid_out = w_own_valid;
    assign txSop_out   = w_own_sop;
    assign txEop_out   = w_own_eop;
    assign grant_out   = state_to_src(r_state);
    assign err_out     = r_err;

    always_comb begin : p_next
        w_state_next = r_state;
        w_hi_run_inc = 1'b0;
        w_hi_run_clr = 1'b0;
        if (r_state == ST_IDLE) begin
            if ((w_hi_run == HI_RUN_LIMIT) && w_req_f2c) begin
                w_state_next = ST_OWN_F2C;
            end else if (w_req_cpl) begin
                w_state_next = ST_OWN_CPL;
            end else if (w_req_mtr) begin
                w_state_next = ST_OWN_MTR;
            end else if (w_req_f2c) begin
                w_state_next = ST_OWN_F2C;
            end
            w_hi_run_clr = !w_req_f2c || (w_state_next == ST_OWN_F2C);
            w_hi_run_inc = w_req_f2c &&
                           ((w_state_next == ST_OWN_CPL) || (w_state_next == ST_OWN_MTR));
        end else if (w_eop_hs) begin
            w_state_next = ST_IDLE;
        end
    end

    // r_first marks that the next owner handshake must carry Sop; any disagreement is a protocol error.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
            r_first <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE) begin
                r_first <= 1'b1;
            end else if (w_hs) begin
                r_first <= 1'b0;
            end
            if (w_hs && (r_first != w_own_sop)) begin
                r_err <= 1'b1;
            end
        end
    end

    tlp_tx_sched_ctr #(
        .WIDTH    (HI_RUN_WIDTH),
        .SATURATE (1'b1),
        .MAX_VAL  (HI_RUN_LIMIT)
    ) u_hi_run (
        .i_clk   (clk_in),
        .i_srst  (reset_in),
        .i_clr   (w_hi_run_clr),
        .i_inc   (w_hi_run_inc),
        .o_count (w_hi_run)
    );

`ifdef TLP_TX_SCHED_STATS_EN
    logic [2:0]            w_stat_inc;
    logic [STAT_WIDTH-1:0] w_stat_count [3];

    assign w_stat_inc[0] = w_eop_hs && (r_state == ST_OWN_CPL);
    assign w_stat_inc[1] = w_eop_hs && (r_state == ST_OWN_MTR);
    assign w_stat_inc[2] = w_eop_hs && (r_state == ST_OWN_F2C);

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        tlp_tx_sched_ctr #(
            .WIDTH    (STAT_WIDTH),
            .SATURATE (1'b0)
        ) u_stat (
            .i_clk   (clk_in),
            .i_srst  (reset_in),
            .i_clr   (1'b0),
            .i_inc   (w_stat_inc[gi]),
            .o_count (w_stat_count[gi])
        );
    end

    assign cplCount_out = w_stat_count[0];
    assign mtrCount_out = w_stat_count[1];
    assign f2cCount_out = w_stat_count[2];
`endif

endmodule

// File: tb/tb_tlp_tx_sched.sv
// Directed bench for tlp_tx_sched: priority order, idle bubble, starvation limit, stalls, errors, reset.
`timescale 1ns/1ps
module tb_tlp_tx_sched;
    import tlp_xcvr_pkg::*;

    localparam int DW         = 64;
    localparam int HI_RUN_MAX = 8;
    localparam int STAT_WIDTH = 32;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic [DW-1:0] cplData_in, mtrData_in, f2cData_in;
    logic          cplValid_in, cplSop_in, cplEop_in, cplReady_out;
    logic          mtrValid_in, mtrSop_in, mtrEop_in, mtrReady_out;
    logic          f2cValid_in, f2cSop_in, f2cEop_in, f2cReady_out;
    logic [DW-1:0] txData_out;
    logic          txValid_out, txSop_out, txEop_out, txReady_in;
    TxSrc          grant_out;
    logic          err_out;
`ifdef TLP_TX_SCHED_STATS_EN
    logic [STAT_WIDTH-1:0] cplCount_out, mtrCount_out, f2cCount_out;
`endif

    always #5 clk_in = ~clk_in;

    tlp_tx_sched #(
        .DATA_WIDTH (DW),
        .HI_RUN_MAX (HI_RUN_MAX),
        .STAT_WIDTH (STAT_WIDTH)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .cplData_in   (cplData_in),
        .cplValid_in  (cplValid_in),
        .cplSop_in    (cplSop_in),
        .cplEop_in    (cplEop_in),
        .cplReady_out (cplReady_out),
        .mtrData_in   (mtrData_in),
        .mtrValid_in  (mtrValid_in),
        .mtrSop_in    (mtrSop_in),
        .mtrEop_in    (mtrEop_in),
        .mtrReady_out (mtrReady_out),
        .f2cData_in   (f2cData_in),
        .f2cValid_in  (f2cValid_in),
        .f2cSop_in    (f2cSop_in),
        .f2cEop_in    (f2cEop_in),
        .f2cReady_out (f2cReady_out),
        .txData_out   (txData_out),
        .txValid_out  (txValid_out),
        .txSop_out    (txSop_out),
        .txEop_out    (txEop_out),
        .txReady_in   (txReady_in),
        .grant_out    (grant_out),
        .err_out      (err_out)
`ifdef TLP_TX_SCHED_STATS_EN
        ,
        .cplCount_out (cplCount_out),
        .mtrCount_out (mtrCount_out),
        .f2cCount_out (f2cCount_out)
`endif
    );

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [63:0] data;
        logic [1:0]  grant;
    } log_t;

    beat_t q_cpl[$];
    beat_t q_mtr[$];
    beat_t q_f2c[$];
    log_t  tx_log[$];

    int          cyc      = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        tx_ready_v;
    logic [1:0]  s_grant;
    logic        s_txv, s_sop, s_eop, s_err;
    logic [63:0] s_txd;
    logic [2:0]  s_rdy;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input int src, input logic [63:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        case (src)
            0:       q_cpl.push_back(b);
            1:       q_mtr.push_back(b);
            default: q_f2c.push_back(b);
        endcase
    endtask

    task automatic push_tlp(input int src, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) push(src, base + 64'(i), (i == 0), (i == n - 1));
    endtask

    task automatic drive();
        cplValid_in = (q_cpl.size() > 0);
        mtrValid_in = (q_mtr.size() > 0);
        f2cValid_in = (q_f2c.size() > 0);
        {cplData_in, cplSop_in, cplEop_in} = cplValid_in ? {q_cpl[0].data, q_cpl[0].sop, q_cpl[0].eop} : '0;
        {mtrData_in, mtrSop_in, mtrEop_in} = mtrValid_in ? {q_mtr[0].data, q_mtr[0].sop, q_mtr[0].eop} : '0;
        {f2cData_in, f2cSop_in, f2cEop_in} = f2cValid_in ? {q_f2c[0].data, q_f2c[0].sop, q_f2c[0].eop} : '0;
        txReady_in = tx_ready_v;
    endtask

    // One clock: sample everything at the falling edge, then retire handshaked beats after the rising edge.
    task automatic step();
        logic hs_c, hs_m, hs_f;
        log_t e;
        @(negedge clk_in);
        s_grant = grant_out;
        s_txv   = txValid_out;
        s_txd   = txData_out;
        s_sop   = txSop_out;
        s_eop   = txEop_out;
        s_err   = err_out;
        s_rdy   = {cplReady_out, mtrReady_out, f2cReady_out};
        hs_c    = cplValid_in && cplReady_out;
        hs_m    = mtrValid_in && mtrReady_out;
        hs_f    = f2cValid_in && f2cReady_out;
        if (txValid_out && txReady_in) begin
            e.cyc   = 32'(cyc);
            e.data  = txData_out;
            e.grant = grant_out;
            tx_log.push_back(e);
            $display("tx cyc=%0d grant=%0d data=0x%h sop=%0b eop=%0b",
                     cyc, grant_out, txData_out, txSop_out, txEop_out);
        end
        @(posedge clk_in);
        #1;
        cyc++;
        if (hs_c) void'(q_cpl.pop_front());
        if (hs_m) void'(q_mtr.pop_front());
        if (hs_f) void'(q_f2c.pop_front());
        drive();
    endtask

    task automatic run_until_idle(input int max_cyc, input string tag);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            step();
            n++;
            done = (q_cpl.size() == 0) && (q_mtr.size() == 0) && (q_f2c.size() == 0) &&
                   (s_grant == SRC_NONE);
        end
        if (!done) check({tag, "_timeout"}, 64'(n), 64'(max_cyc + 1));
    endtask

    task automatic check_entry(input string tag, input int idx, input logic [63:0] data,
                               input logic [1:0] grant);
        if (idx < tx_log.size()) begin
            check({tag, "_data"}, tx_log[idx].data, data);
            check({tag, "_grant"}, 64'(tx_log[idx].grant), 64'(grant));
        end else begin
            check({tag, "_missing"}, 64'(tx_log.size()), 64'(idx + 1));
        end
    endtask

    task automatic check_gap(input string tag, input int idx, input int gap);
        if (idx < tx_log.size() && idx > 0) begin
            check(tag, 64'(tx_log[idx].cyc - tx_log[idx-1].cyc), 64'(gap));
        end else begin
            check({tag, "_missing"}, 64'(tx_log.size()), 64'(idx + 1));
        end
    endtask

    task automatic pulse_reset();
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        q_cpl.delete();
        q_mtr.delete();
        q_f2c.delete();
        drive();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ci, fi;
        reset_in   = 1'b1;
        tx_ready_v = 1'b1;
        drive();
        repeat (3) step();
        check("rst_grant", 64'(s_grant), 64'(SRC_NONE));
        check("rst_txvalid", 64'(s_txv), 0);
        check("rst_txsop_eop", 64'({s_sop, s_eop}), 0);
        check("rst_ready", 64'(s_rdy), 0);
        check("rst_err", 64'(s_err), 0);
        reset_in = 1'b0;
        step();

        // 1: single-beat CPL
        push(0, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b1);
        drive();
        step();
        check("t1_req_grant", 64'(s_grant), 64'(SRC_NONE));
        check("t1_req_txvalid", 64'(s_txv), 0);
        step();
        check("t1_grant", 64'(s_grant), 64'(SRC_CPL));
        check("t1_txvalid", 64'(s_txv), 1);
        check("t1_txdata", s_txd, 64'hDEADBEEF_CAFEF00D);
        check("t1_sop_eop", 64'({s_sop, s_eop}), 64'b11);
        check("t1_ready", 64'(s_rdy), 64'b100);
        step();
        check("t1_back_idle", 64'(s_grant), 64'(SRC_NONE));
        check("t1_idle_txvalid", 64'(s_txv), 0);

        // 2: simultaneous CPL, MTR, 4-beat F2C
        tx_log.delete();
        push_tlp(0, 64'h100, 1);
        push_tlp(1, 64'h200, 1);
        push_tlp(2, 64'h300, 4);
        drive();
        run_until_idle(40, "t2");
        check("t2_beats", 64'(tx_log.size()), 6);
        check_entry("t2_e0", 0, 64'h100, SRC_CPL);
        check_entry("t2_e1", 1, 64'h200, SRC_MTR);
        for (int i = 0; i < 4; i++) check_entry("t2_f2c", 2 + i, 64'h300 + 64'(i), SRC_F2C);
        check_gap("t2_gap_cpl_mtr", 1, 2);
        check_gap("t2_gap_mtr_f2c", 2, 2);
        for (int i = 3; i < 6; i++) check_gap("t2_gap_f2c_burst", i, 1);

        // 3: continuous CPL with F2C waiting, HI_RUN_MAX=8
        tx_log.delete();
        for (int i = 0; i < 20; i++) push_tlp(0, 64'h1000 + 64'(i), 1);
        push_tlp(2, 64'h2000, 1);
        push_tlp(2, 64'h2001, 1);
        drive();
        run_until_idle(200, "t3");
        check("t3_beats", 64'(tx_log.size()), 22);
        ci = 0;
        fi = 0;
        for (int k = 0; k < 22; k++) begin
            if ((k % 9) == 8 && fi < 2) begin
                check_entry("t3_f2c", k, 64'h2000 + 64'(fi), SRC_F2C);
                fi++;
            end else begin
                check_entry("t3_cpl", k, 64'h1000 + 64'(ci), SRC_CPL);
                ci++;
            end
        end

        // 4: F2C stalled by txReady at beat 2, MTR arrives mid-TLP
        tx_log.delete();
        push_tlp(2, 64'h4000, 4);
        drive();
        step();
        step();
        tx_ready_v = 1'b0;
        push_tlp(1, 64'h5000, 1);
        drive();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_hold_grant", 64'(s_grant), 64'(SRC_F2C));
            check("t4_hold_mtr_rdy", 64'(s_rdy[1]), 0);
            check("t4_hold_data", s_txd, 64'h4001);
        end
        tx_ready_v = 1'b1;
        drive();
        run_until_idle(40, "t4");
        check("t4_beats", 64'(tx_log.size()), 5);
        for (int i = 0; i < 4; i++) check_entry("t4_f2c", i, 64'h4000 + 64'(i), SRC_F2C);
        check_entry("t4_mtr", 4, 64'h5000, SRC_MTR);
        check_gap("t4_gap_stall", 1, 6);
        check_gap("t4_gap_mtr_after_eop", 4, 2);

        // 5: protocol errors
        check("t5_err_pre", 64'(s_err), 0);
        push(0, 64'h6000, 1'b1, 1'b1);
        drive();
        step();
        cplSop_in = 1'b0;
        step();
        check("t5_fwd_data", s_txd, 64'h6000);
        step();
        check("t5_err_set", 64'(s_err), 1);
        check("t5_grant_idle", 64'(s_grant), 64'(SRC_NONE));
        step();
        step();
        check("t5_err_sticky", 64'(s_err), 1);
        pulse_reset();
        step();
        check("t5_err_cleared", 64'(s_err), 0);
        check("t5_grant_reset", 64'(s_grant), 64'(SRC_NONE));
        push(0, 64'h6100, 1'b1, 1'b0);
        push(0, 64'h6101, 1'b1, 1'b1);
        drive();
        run_until_idle(20, "t5b");
        check("t5b_err_sop_mid", 64'(s_err), 1);
        pulse_reset();
        step();
        check("t5b_err_cleared", 64'(s_err), 0);

        // 6: mixed traffic, counters, reset mid-TLP
        tx_log.delete();
        for (int i = 0; i < 3; i++) push_tlp(0, 64'h7100 + 64'(i), 1);
        for (int i = 0; i < 2; i++) push_tlp(1, 64'h7200 + 64'(i), 1);
        for (int i = 0; i < 5; i++) push_tlp(2, 64'h7300 + 64'(i), 1);
        drive();
        run_until_idle(100, "t6");
        check("t6_beats", 64'(tx_log.size()), 10);
`ifdef TLP_TX_SCHED_STATS_EN
        check("t6_cpl_count", 64'(cplCount_out), 3);
        check("t6_mtr_count", 64'(mtrCount_out), 2);
        check("t6_f2c_count", 64'(f2cCount_out), 5);
`endif
        push_tlp(2, 64'h7400, 4);
        drive();
        step();
        step();
        reset_in = 1'b1;
        step();
        check("t6_valid_before_rst", 64'(s_txv), 1);
        reset_in = 1'b0;
        q_cpl.delete();
        q_mtr.delete();
        q_f2c.delete();
        drive();
        step();
        check("t6_valid_after_rst", 64'(s_txv), 0);
        check("t6_grant_after_rst", 64'(s_grant), 64'(SRC_NONE));
`ifdef TLP_TX_SCHED_STATS_EN
        check("t6_cpl_count_rst", 64'(cplCount_out), 0);
        check("t6_mtr_count_rst", 64'(mtrCount_out), 0);
        check("t6_f2c_count_rst", 64'(f2cCount_out), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
